if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS/DLX pipeline, directly upstream of instruction decode.
- Holds the PC and selects the next PC:
  - PC+4 by default.
  - Branch target when PC_sel from the ID-stage branch logic is asserted.
  - Jump target on a jump.
- Drives the synchronous instruction memory and owns the IF/ID pipeline register, including flush on redirect and hold on hazard stall.
- Run/step/halt FSM lets the UART debug unit start, single-step and stop fetch.

---
 rtl/if_fetch_stage.sv | 135 +++++++++++++
 tb/tb_if_fetch_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage : PC / next-PC selection, IF/ID register, run/step/halt FSM
// Revision 1.0
// ============================================================================
`default_nettype none

module if_fetch_stage #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [5:0]            HALT_OPCODE = 6'b111111
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  PC_sel,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    input  logic                  jump_sel,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  stall,
    input  logic                  dbg_run,
    input  logic                  dbg_step,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_data,
    output logic [31:0]           IF_ID_instr,
    output logic [ADDR_WIDTH-1:0] IF_ID_pc_plus4,
    output logic                  IF_ID_valid,
    output logic                  halted
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_STEP = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] c_FOUR = ADDR_WIDTH'(4);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic                  w_active;
    logic                  w_adv;
    logic                  w_redirect;
    logic                  w_halt_hit;
    logic [31:0]           r_instr;
    logic [ADDR_WIDTH-1:0] r_pc_plus4;
    logic                  r_valid;
    logic                  r_halted;

    assign w_active   = (r_state == c_ST_RUN) || (r_state == c_ST_STEP);
    assign w_adv      = w_active && !stall;
    assign w_redirect = jump_sel || PC_sel;
    assign w_halt_hit = w_adv && (imem_data[31:26] == HALT_OPCODE);
    assign w_pc_plus4 = r_pc + c_FOUR;

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (!w_active || stall) begin
            w_next_pc = r_pc;
        end else if (jump_sel) begin
            w_next_pc = jump_addr;
        end else if (PC_sel) begin
            w_next_pc = branch_addr;
        end
    end

    // The RAM registers this address, so imem_data always matches r_pc.
    assign imem_addr = w_next_pc;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (dbg_run) begin
                    w_state_next = c_ST_RUN;
                end else if (dbg_step) begin
                    w_state_next = c_ST_STEP;
                end
            end
            c_ST_RUN: begin
                if (w_halt_hit) begin
                    w_state_next = c_ST_DONE;
                end else if (!dbg_run) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_STEP: begin
                w_state_next = w_halt_hit ? c_ST_DONE : c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_DONE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= c_ST_IDLE;
            r_halted <= 1'b1;
            r_pc     <= RESET_PC;
        end else begin
            r_state  <= w_state_next;
            r_halted <= (w_state_next == c_ST_IDLE) || (w_state_next == c_ST_DONE);
            r_pc     <= w_next_pc;
        end
    end

    // Redirect flushes the wrong-path word; idle cycles insert bubbles but keep pc_plus4.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (w_adv && w_redirect) begin
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (w_adv) begin
            r_instr    <= imem_data;
            r_pc_plus4 <= w_pc_plus4;
            r_valid    <= 1'b1;
        end else if (!stall) begin
            r_instr    <= '0;
            r_valid    <= 1'b0;
        end
    end

    assign IF_ID_instr    = r_instr;
    assign IF_ID_pc_plus4 = r_pc_plus4;
    assign IF_ID_valid    = r_valid;
    assign halted         = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// tb_if_fetch_stage : directed self-checking bench for if_fetch_stage
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        PC_sel;
    logic [31:0] branch_addr;
    logic        jump_sel;
    logic [31:0] jump_addr;
    logic        stall;
    logic        dbg_run;
    logic        dbg_step;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_pc_plus4;
    logic        IF_ID_valid;
    logic        halted;

    logic [31:0] mem [0:63];
    int          n_checks;
    int          n_fail;

    if_fetch_stage #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0),
        .HALT_OPCODE(6'b111111)
    ) dut (
        .clock         (clk),
        .reset         (rst_n),
        .PC_sel        (PC_sel),
        .branch_addr   (branch_addr),
        .jump_sel      (jump_sel),
        .jump_addr     (jump_addr),
        .stall         (stall),
        .dbg_run       (dbg_run),
        .dbg_step      (dbg_step),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_pc_plus4(IF_ID_pc_plus4),
        .IF_ID_valid   (IF_ID_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction RAM
    always @(posedge clk) imem_data <= mem[imem_addr[7:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        PC_sel = 0; branch_addr = 0; jump_sel = 0; jump_addr = 0;
        stall = 0; dbg_run = 0; dbg_step = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4} !== {1'b0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_ifid: got v=%0b i=%h p=%h expected 0/0/0", IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4);
        end
        n_checks++;
        if ({halted, imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got halted=%0b addr=%h expected 1/0", halted, imem_addr);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({halted, IF_ID_valid, imem_addr} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL idle_after_reset: got halted=%0b v=%0b addr=%h expected 1/0/0", halted, IF_ID_valid, imem_addr);
        end
    endtask

    task automatic test_run();
        logic [31:0] exp_instr;
        dbg_run = 1'b1;
        tick();
        n_checks++;
        if ({halted, IF_ID_valid, imem_addr} !== {1'b0, 1'b0, 32'h4}) begin
            n_fail++;
            $display("FAIL run_start: got halted=%0b v=%0b addr=%h expected 0/0/4", halted, IF_ID_valid, imem_addr);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_instr = k;
            n_checks++;
            if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr} !== {1'b1, exp_instr, 32'(4 * k), 32'(4 * k + 4)}) begin
                n_fail++;
                $display("FAIL run_seq%0d: got v=%0b i=%h p=%h addr=%h expected 1/%h/%h/%h",
                         k, IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr, exp_instr, 4 * k, 4 * k + 4);
            end
        end
    endtask

    task automatic test_branch();
        PC_sel = 1'b1; branch_addr = 32'h40;
        #1;
        n_checks++;
        if (imem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL branch_addr: got %h expected 00000040", imem_addr);
        end
        tick();
        PC_sel = 1'b0; branch_addr = 32'h0;
        #1;
        n_checks++;
        if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'h44}) begin
            n_fail++;
            $display("FAIL branch_flush: got v=%0b i=%h p=%h addr=%h expected 0/0/0/44", IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr);
        end
        tick();
        n_checks++;
        if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4} !== {1'b1, 32'd17, 32'h44}) begin
            n_fail++;
            $display("FAIL branch_target: got v=%0b i=%h p=%h expected 1/11/44", IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4);
        end
    endtask

    task automatic test_jump_branch();
        PC_sel = 1'b1; branch_addr = 32'h40; jump_sel = 1'b1; jump_addr = 32'h80;
        #1;
        n_checks++;
        if (imem_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL jump_priority: got %h expected 00000080", imem_addr);
        end
        tick();
        PC_sel = 1'b0; jump_sel = 1'b0;
        #1;
        n_checks++;
        if ({IF_ID_valid, IF_ID_instr, imem_addr} !== {1'b0, 32'h0, 32'h84}) begin
            n_fail++;
            $display("FAIL jump_flush: got v=%0b i=%h addr=%h expected 0/0/84", IF_ID_valid, IF_ID_instr, imem_addr);
        end
        tick();
        n_checks++;
        if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4} !== {1'b1, 32'd33, 32'h84}) begin
            n_fail++;
            $display("FAIL jump_target: got v=%0b i=%h p=%h expected 1/21/84", IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4);
        end
        // Redirect requests during stall are ignored
        stall = 1'b1; PC_sel = 1'b1; jump_sel = 1'b1;
        #1;
        n_checks++;
        if (imem_addr !== 32'h84) begin
            n_fail++;
            $display("FAIL stall_redirect_addr: got %h expected 00000084", imem_addr);
        end
        tick();
        n_checks++;
        if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr} !== {1'b1, 32'd33, 32'h84, 32'h84}) begin
            n_fail++;
            $display("FAIL stall_redirect_hold: got v=%0b i=%h p=%h addr=%h expected 1/21/84/84", IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr);
        end
        stall = 1'b0; PC_sel = 1'b0; jump_sel = 1'b0;
        tick();
        n_checks++;
        if ({IF_ID_instr, IF_ID_pc_plus4} !== {32'd34, 32'h88}) begin
            n_fail++;
            $display("FAIL stall_redirect_resume: got i=%h p=%h expected 22/88", IF_ID_instr, IF_ID_pc_plus4);
        end
    endtask

    task automatic test_stall();
        jump_sel = 1'b1; jump_addr = 32'h1C;
        tick();
        jump_sel = 1'b0;
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr} !== {1'b1, 32'd8, 32'h20, 32'h20}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%0b i=%h p=%h addr=%h expected 1/8/20/20", k, IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr);
            end
            tick();
        end
        stall = 1'b0;
        #1;
        n_checks++;
        if ({IF_ID_instr, IF_ID_pc_plus4} !== {32'd8, 32'h20}) begin
            n_fail++;
            $display("FAIL stall_last: got i=%h p=%h expected 8/20", IF_ID_instr, IF_ID_pc_plus4);
        end
        tick();
        n_checks++;
        if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4} !== {1'b1, 32'd9, 32'h24}) begin
            n_fail++;
            $display("FAIL stall_release: got v=%0b i=%h p=%h expected 1/9/24", IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4);
        end
        // pc+4 wraps around the top of the address space
        jump_sel = 1'b1; jump_addr = 32'hFFFF_FFFC;
        tick();
        jump_sel = 1'b0;
        #1;
        n_checks++;
        if (imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_addr: got %h expected 00000000", imem_addr);
        end
        tick();
        n_checks++;
        if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4} !== {1'b1, 32'd64, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_ifid: got v=%0b i=%h p=%h expected 1/40/0", IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4);
        end
    endtask

    task automatic test_step();
        int n_valid;
        n_valid = 0;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            dbg_step = 1'b1;
            tick();
            dbg_step = 1'b0;
            n_checks++;
            if ({halted, IF_ID_valid, IF_ID_pc_plus4, imem_addr} !== {1'b0, 1'b0, 32'(4 * (k - 1)), 32'(4 * k)}) begin
                n_fail++;
                $display("FAIL step%0d_bubble: got h=%0b v=%0b p=%h addr=%h expected 0/0/%h/%h",
                         k, halted, IF_ID_valid, IF_ID_pc_plus4, imem_addr, 4 * (k - 1), 4 * k);
            end
            tick();
            if (IF_ID_valid) n_valid++;
            n_checks++;
            if ({halted, IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr} !== {1'b1, 1'b1, 32'(k), 32'(4 * k), 32'(4 * k)}) begin
                n_fail++;
                $display("FAIL step%0d_fetch: got h=%0b v=%0b i=%h p=%h addr=%h expected 1/1/%h/%h/%h",
                         k, halted, IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr, k, 4 * k, 4 * k);
            end
        end
        tick();
        if (IF_ID_valid) n_valid++;
        n_checks++;
        if (n_valid !== 3 || imem_addr !== 32'hC || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL step_total: got valid=%0d addr=%h h=%0b expected 3/c/1", n_valid, imem_addr, halted);
        end
    endtask

    task automatic test_halt();
        mem[3] = 32'hFC00_0000;
        do_reset();
        dbg_run = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if ({halted, IF_ID_instr, IF_ID_pc_plus4} !== {1'b0, 32'd3, 32'hC}) begin
            n_fail++;
            $display("FAIL halt_pre: got h=%0b i=%h p=%h expected 0/3/c", halted, IF_ID_instr, IF_ID_pc_plus4);
        end
        tick();
        n_checks++;
        if ({halted, IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr} !== {1'b1, 1'b1, 32'hFC00_0000, 32'h10, 32'h10}) begin
            n_fail++;
            $display("FAIL halt_latch: got h=%0b v=%0b i=%h p=%h addr=%h expected 1/1/fc000000/10/10",
                     halted, IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr);
        end
        for (int k = 0; k < 4; k++) begin
            dbg_run = k[0];
            tick();
            n_checks++;
            if ({halted, IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr} !== {1'b1, 1'b0, 32'h0, 32'h10, 32'h10}) begin
                n_fail++;
                $display("FAIL halt_stuck%0d: got h=%0b v=%0b i=%h p=%h addr=%h expected 1/0/0/10/10",
                         k, halted, IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr);
            end
        end
        // Asynchronous reset takes effect between edges
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({halted, IF_ID_pc_plus4, imem_addr} !== {1'b1, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL halt_async_reset: got h=%0b p=%h addr=%h expected 1/0/0", halted, IF_ID_pc_plus4, imem_addr);
        end
        dbg_run = 1'b0;
        tick();
        rst_n = 1'b1;
        dbg_run = 1'b1;
        tick();
        n_checks++;
        if ({halted, imem_addr} !== {1'b0, 32'h4}) begin
            n_fail++;
            $display("FAIL post_done_reset_idle: got h=%0b addr=%h expected 0/4", halted, imem_addr);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1);
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_run();
        test_branch();
        test_jump_branch();
        test_stall();
        test_step();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
